// File: rtl/tt_pkg.sv
// Shared types and sizing for the truth-table sweeper.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam int NUM_ROWS = 8;
  localparam int ROW_W    = 3;

endpackage

// File: rtl/settle_timer.sv
// Per-row settle down-counter: load has priority, otherwise counts down to zero and stops.
module settle_timer #(
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [SETTLE_W-1:0] load_val_i,
  input  logic                en_i,
  output logic                zero_o
);

  logic [SETTLE_W-1:0] count_q;
  logic [SETTLE_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - {{(SETTLE_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 8 input rows of a 3-input logic block, samples its output after a
// programmable settle time and compares the measured table to an expected code.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int SETTLE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          expected,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic                in1,
  output logic                in2,
  output logic                in3,
  input  logic                fn_out,
  output logic                busy,
  output logic                done,
  output logic [7:0]          measured,
  output logic [7:0]          mismatch,
  output logic                pass
);

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [7:0]          expected_q, expected_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [7:0]          measured_q, measured_d;
  logic [7:0]          mismatch_q, mismatch_d;
  logic                pass_q, pass_d;

  logic                timer_load;
  logic [SETTLE_W-1:0] timer_val;
  logic                timer_en;
  logic                timer_zero;

  settle_timer #(
    .SETTLE_W (SETTLE_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .en_i       (timer_en),
    .zero_o     (timer_zero)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    expected_d = expected_q;
    settle_d   = settle_q;
    measured_d = measured_q;
    mismatch_d = mismatch_q;
    pass_d     = pass_q;
    timer_load = 1'b0;
    timer_val  = settle_q;
    timer_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          expected_d = expected;
          settle_d   = settle_cycles;
          row_d      = '0;
          measured_d = '0;
          timer_load = 1'b1;
          timer_val  = settle_cycles;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!timer_zero) begin
          timer_en = 1'b1;
        end else begin
          measured_d[row_q] = fn_out;
          if (row_q == ROW_W'(NUM_ROWS - 1)) begin
            // Result registers load on entry to FINISH so they are valid while done is high.
            mismatch_d = measured_d ^ expected_q;
            pass_d     = (measured_d == expected_q);
            state_d    = ST_FINISH;
          end else begin
            row_d      = row_q + 3'd1;
            timer_load = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      expected_q <= '0;
      settle_q   <= '0;
      measured_q <= '0;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      expected_q <= expected_d;
      settle_q   <= settle_d;
      measured_q <= measured_d;
      mismatch_q <= mismatch_d;
      pass_q     <= pass_d;
    end
  end

  assign in1      = row_q[2];
  assign in2      = row_q[1];
  assign in3      = row_q[0];
  assign busy     = (state_q == ST_HOLD);
  assign done     = (state_q == ST_FINISH);
  assign measured = measured_q;
  assign mismatch = mismatch_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: table of sweeps with a result scoreboard, plus hand-written
// sequences for mid-sweep start/expected changes and asynchronous reset.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] expected;
  logic [7:0] settle_cycles;
  logic       in1, in2, in3;
  logic       fn_out;
  logic       busy, done;
  logic [7:0] measured, mismatch;
  logic       pass;

  truth_table_sweeper #(.SETTLE_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .expected      (expected),
    .settle_cycles (settle_cycles),
    .in1           (in1),
    .in2           (in2),
    .in3           (in3),
    .fn_out        (fn_out),
    .busy          (busy),
    .done          (done),
    .measured      (measured),
    .mismatch      (mismatch),
    .pass          (pass)
  );

  always #5 clk = ~clk;

  // Model of the block under characterisation; optional glitch on the first 3 cycles of a row.
  logic [7:0] func_r = 8'h00;
  bit         glitch_en = 1'b0;
  int         hold_cnt = 0;
  logic [2:0] last_row = 3'd0;
  logic [2:0] row_w;
  assign row_w  = {in1, in2, in3};
  assign fn_out = func_r[row_w] ^ (glitch_en && (hold_cnt < 3));

  always @(negedge clk) begin
    if (row_w != last_row) begin
      hold_cnt = 0;
      last_row = row_w;
    end else begin
      hold_cnt = hold_cnt + 1;
    end
  end

  typedef struct {
    logic [7:0] s;
    logic [7:0] exp;
    logic [7:0] func;
    bit         glitch;
    bit         interfere;
    logic [7:0] m;
    logic [7:0] mm;
    bit         p;
  } vec_t;

  typedef struct {
    logic [7:0] m;
    logic [7:0] mm;
    bit         p;
    int         lat;
  } res_t;

  res_t sb[$];
  vec_t vecs[7];

  int   n_checks = 0;
  int   n_pass   = 0;
  logic [7:0] prev_mm   = 8'h00;
  logic       prev_pass = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  // Caller must be positioned at a negedge; returns at the negedge after done.
  task automatic run_sweep(input vec_t v);
    int   lat;
    int   budget;
    res_t exp_r;
    func_r        = v.func;
    glitch_en     = v.glitch;
    settle_cycles = v.s;
    expected      = v.exp;
    start         = 1'b1;
    exp_r.m   = v.m;
    exp_r.mm  = v.mm;
    exp_r.p   = v.p;
    exp_r.lat = 8 * (v.s + 1) + 1;
    sb.push_back(exp_r);
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    chk("busy_rise", busy, 1);
    chk("measured_clear", measured, 0);
    chk("mismatch_held", mismatch, prev_mm);
    chk("pass_held", pass, prev_pass);
    budget = 8 * (v.s + 1) + 40;
    while (done !== 1'b1 && lat < budget) begin
      if (v.interfere && lat == 5) begin
        start         = 1'b1;
        expected      = 8'h00;
        settle_cycles = 8'h00;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    exp_r = sb.pop_front();
    if (done !== 1'b1) begin
      chk("done_timeout", done, 1);
      return;
    end
    chk("latency", lat, exp_r.lat);
    chk("measured", measured, exp_r.m);
    chk("mismatch", mismatch, exp_r.mm);
    chk("pass", pass, exp_r.p);
    chk("busy_during_done", busy, 0);
    prev_mm   = exp_r.mm;
    prev_pass = exp_r.p;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("idle_inputs", {in1, in2, in3}, 3'b111);
    chk("mismatch_hold", mismatch, exp_r.mm);
  endtask

  initial begin
    //                 S      exp    func   glt int  meas   mm     pass
    vecs[0] = '{8'd0,   8'hCD, 8'hCD, 0, 0, 8'hCD, 8'h00, 1};
    vecs[1] = '{8'd3,   8'hCF, 8'hCD, 0, 0, 8'hCD, 8'h02, 0};
    vecs[2] = '{8'd3,   8'hCD, 8'hCD, 1, 0, 8'hCD, 8'h00, 1};
    vecs[3] = '{8'd2,   8'h5A, 8'hA5, 0, 0, 8'hA5, 8'hFF, 0};
    vecs[4] = '{8'd0,   8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1};
    vecs[5] = '{8'd1,   8'hFF, 8'hFE, 0, 0, 8'hFE, 8'h01, 0};
    vecs[6] = '{8'd255, 8'h81, 8'h81, 0, 0, 8'h81, 8'h00, 1};

    rst = 1'b1;
    start = 1'b0;
    expected = 8'h00;
    settle_cycles = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_inputs", {in1, in2, in3}, 3'b000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_measured", measured, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_pass", pass, 0);

    // Back-to-back: each sweep starts in the cycle right after the previous done.
    for (int i = 0; i < 7; i++) run_sweep(vecs[i]);

    // Restart request plus expected/settle change mid-sweep must be ignored.
    run_sweep('{8'd2, 8'h3C, 8'h3C, 0, 1, 8'h3C, 8'h00, 1});

    // Leave a non-zero mismatch behind before the mid-sweep reset.
    run_sweep(vecs[3]);

    @(negedge clk);
    func_r        = 8'hCD;
    glitch_en     = 1'b0;
    settle_cycles = 8'd1;
    expected      = 8'hCD;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40 && row_w != 3'd4; k++) @(negedge clk);
    chk("reached_row4", row_w, 3'd4);
    rst = 1'b1;
    #1;
    chk("arst_inputs", {in1, in2, in3}, 3'b000);
    chk("arst_busy", busy, 0);
    chk("arst_measured", measured, 0);
    chk("arst_mismatch", mismatch, 0);
    chk("arst_pass", pass, 0);
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (done === 1'b1) saw_done = 1'b1;
      end
      chk("arst_no_done", saw_done, 0);
    end
    rst = 1'b0;
    prev_mm   = 8'h00;
    prev_pass = 1'b0;
    @(negedge clk);
    chk("arst_idle_done", done, 0);
    run_sweep(vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that characterises one 3-input logic function block (in1, in2, in3 -> out) by sweeping all 8 input combinations.
- Holds each combination for a programmable settle time and samples the block output into an 8-bit measured truth table.
- Compares the measured table against an expected hex code (e.g. 0xCD) and reports pass/fail plus a per-row mismatch mask.
- Sits between the test/config host and the logic-function instance under characterisation.

Parameters:
SETTLE_W, 8, width of settle_cycles; maximum hold is 2^SETTLE_W cycles per row

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a sweep; sampled only in IDLE
expected  input  8  expected truth table; bit i = out for {in1,in2,in3} = i
settle_cycles  input  SETTLE_W  extra hold cycles per row (S)
in1  output  1  function input, MSB of row index
in2  output  1  function input
in3  output  1  function input, LSB of row index
fn_out  input  1  function output, synchronous to clk
busy  output  1  sweep in progress
done  output  1  one-cycle pulse, sweep complete
measured  output  8  captured truth table, bit i = fn_out sampled for row i
mismatch  output  8  measured XOR captured expected, valid from done onward
pass  output  1  1 when mismatch == 0, valid from done onward

Behaviour:
- Reset values: in1/in2/in3 = 0, busy = 0, done = 0, measured = 0x00, mismatch = 0x00, pass = 0, FSM = IDLE, row index = 0, timer = 0.
- States: IDLE, HOLD, FINISH.
- IDLE:
  - start = 1 captures expected and settle_cycles (S) into internal registers.
  - Sets row = 0, {in1,in2,in3} = 3'b000, timer = S, clears measured to 0x00, busy = 1, and enters HOLD.
- HOLD:
  - Each cycle with timer != 0: timer decrements.
  - When timer == 0 in a cycle: measured[row] <= fn_out.
    - If row == 7: go to FINISH.
    - Otherwise: row increments, {in1,in2,in3} <= row+1, timer <= S.
  - Each row's input combination is therefore held for exactly S+1 cycles, and fn_out is sampled on the last of those cycles.
- FINISH (one cycle):
  - done = 1, mismatch <= measured ^ expected_q, pass <= (measured == expected_q).
  - busy = 0 from the next cycle; return to IDLE.
  - In IDLE, inputs remain at 3'b111.
- Latency: busy rises the cycle after start is accepted; done asserts 8*(S+1)+1 cycles after start is accepted.
- measured, mismatch and pass hold their values until the next accepted start. On that start, measured clears immediately; mismatch and pass update only at the next FINISH.
- start while busy (HOLD or FINISH) is ignored, not queued.
- Changes on expected or settle_cycles mid-sweep have no effect, because both are captured at start.
- S = 0 is legal: one cycle per row.
- S = max: no overflow, because the timer only decrements.
- Asynchronous rst mid-sweep returns everything to reset values immediately. No done pulse is produced.
- done and busy are never high in the same cycle.

Decomposition:
- Shared package tt_pkg: state enum (IDLE, HOLD, FINISH), NUM_ROWS = 8, ROW_W = 3.
- One natural sub-module, settle_timer: down-counter with load/zero-flag, parameterised by SETTLE_W, instantiated once.

Test Plan:
- S = 0, fn_out driven as the 0xCD function of {in1,in2,in3}, expected = 0xCD -> rows 0..7 each held 1 cycle; done 9 cycles after start; measured = 0xCD, mismatch = 0x00, pass = 1.
- S = 3, same function, expected = 0xCF -> each row held 4 cycles; done at cycle 33; measured = 0xCD, mismatch = 0x02, pass = 0.
- fn_out changes only on cycles 0..2 of each row with S = 3 (glitch, then settle to 0xCD value) -> measured = 0xCD, proving sampling occurs on the last hold cycle.
- start pulsed again during HOLD, and expected changed to 0x00 mid-sweep -> no restart; result is computed against the originally captured expected.
- rst asserted at row 4 -> all outputs return to reset values immediately with no done pulse; a new start then completes a full normal sweep.
- Back-to-back: start asserted in the cycle immediately after done -> accepted; measured clears to 0x00, and the previous pass/mismatch are held until the new FINISH.
